// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing the transfer engine's single byte-write port.
// Optional macro UART_TX_ARB_RETRY_EN: re-issue a timed-out byte up to twice before req_err.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int W_ID  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_err,
  output logic               grant_valid,
  output logic [W_ID-1:0]    grant_id,
  output logic               write_enable,
  output logic [7:0]         write_data,
  input  logic               write_busy,
  input  logic               write_ack,
  input  logic               write_ack_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT_ACK, S_WAIT_BUSY} state_t;

  state_t           state_q, state_d;
  logic [W_ID-1:0]  rr_q, rr_d;
  logic [W_ID-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             lock_q, lock_d;
  logic             write_enable_q, write_enable_d;
  logic [7:0]       write_data_q, write_data_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic [N_REQ-1:0] req_done_q, req_done_d;
  logic [N_REQ-1:0] req_err_q, req_err_d;
`ifdef UART_TX_ARB_RETRY_EN
  logic [1:0]       retry_q, retry_d;
  logic             again_q, again_d;
`endif

  logic             pick_found;
  logic [W_ID-1:0]  pick_id;
  logic [7:0]       pick_data, owner_data;

  function automatic logic [N_REQ-1:0] onehot(input logic [W_ID-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  // First pending requester after the last owner, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % N_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = W_ID'(idx);
      end
    end
  end

  assign pick_data  = req_data[8*pick_id +: 8];
  assign owner_data = req_data[8*grant_id_q +: 8];

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    grant_id_d     = grant_id_q;
    grant_valid_d  = grant_valid_q;
    lock_d         = lock_q;
    write_enable_d = 1'b0;
    write_data_d   = write_data_q;
    req_ready_d    = '0;
    req_done_d     = '0;
    req_err_d      = '0;
`ifdef UART_TX_ARB_RETRY_EN
    retry_d        = retry_q;
    again_d        = again_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lock_q) begin
          if (!req_valid[grant_id_q]) begin
            lock_d        = 1'b0;
            grant_valid_d = 1'b0;
          end else if (!write_busy) begin
            state_d        = S_ISSUE;
            write_enable_d = 1'b1;
            write_data_d   = owner_data;
            req_ready_d    = onehot(grant_id_q);
          end
        end else if (|req_valid && !write_busy) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (pick_found && !write_busy) begin
          state_d        = S_ISSUE;
          grant_valid_d  = 1'b1;
          grant_id_d     = pick_id;
          write_enable_d = 1'b1;
          write_data_d   = pick_data;
          req_ready_d    = onehot(pick_id);
        end else begin
          state_d       = S_IDLE;
          grant_valid_d = 1'b0;
        end
      end
      S_ISSUE: begin
        rr_d    = grant_id_q;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (write_ack) begin
          req_done_d = onehot(grant_id_q);
          lock_d     = req_lock[grant_id_q];
          state_d    = S_WAIT_BUSY;
`ifdef UART_TX_ARB_RETRY_EN
          retry_d    = 2'd0;
`endif
        end else if (write_ack_timeout) begin
          state_d = S_WAIT_BUSY;
`ifdef UART_TX_ARB_RETRY_EN
          if (retry_q != 2'd2) begin
            retry_d = retry_q + 2'd1;
            again_d = 1'b1;
          end else begin
            retry_d   = 2'd0;
            req_err_d = onehot(grant_id_q);
            lock_d    = req_lock[grant_id_q];
          end
`else
          req_err_d = onehot(grant_id_q);
          lock_d    = req_lock[grant_id_q];
`endif
        end
      end
      S_WAIT_BUSY: begin
        if (!write_busy) begin
`ifdef UART_TX_ARB_RETRY_EN
          // A retry resends the latched byte without a second req_ready.
          if (again_q) begin
            again_d        = 1'b0;
            state_d        = S_ISSUE;
            write_enable_d = 1'b1;
          end else begin
            state_d       = S_IDLE;
            grant_valid_d = lock_q;
          end
`else
          state_d       = S_IDLE;
          grant_valid_d = lock_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_q           <= W_ID'(N_REQ - 1);
      grant_id_q     <= '0;
      grant_valid_q  <= 1'b0;
      lock_q         <= 1'b0;
      write_enable_q <= 1'b0;
      write_data_q   <= '0;
      req_ready_q    <= '0;
      req_done_q     <= '0;
      req_err_q      <= '0;
`ifdef UART_TX_ARB_RETRY_EN
      retry_q        <= 2'd0;
      again_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      grant_id_q     <= grant_id_d;
      grant_valid_q  <= grant_valid_d;
      lock_q         <= lock_d;
      write_enable_q <= write_enable_d;
      write_data_q   <= write_data_d;
      req_ready_q    <= req_ready_d;
      req_done_q     <= req_done_d;
      req_err_q      <= req_err_d;
`ifdef UART_TX_ARB_RETRY_EN
      retry_q        <= retry_d;
      again_q        <= again_d;
`endif
    end
  end

  assign req_ready    = req_ready_q;
  assign req_done     = req_done_q;
  assign req_err      = req_err_q;
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign write_enable = write_enable_q;
  assign write_data   = write_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: expected writes and completions are queued
// when requests are posted and checked as the DUT emits write_enable / req_done / req_err.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_lock;
  logic [N-1:0]   req_ready, req_done, req_err;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           write_enable;
  logic [7:0]     write_data;
  logic           write_busy, write_ack, write_ack_timeout;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .write_enable(write_enable), .write_data(write_data),
    .write_busy(write_busy), .write_ack(write_ack), .write_ack_timeout(write_ack_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [7:0] data; logic rdy; } wexp_t;
  typedef struct packed { logic [1:0] id; logic err; } cexp_t;

  wexp_t      wq[$];
  cexp_t      cq[$];
  int         total, bad, cyc;
  int         issued[N], accepted[N];
  logic [7:0] base[N];
  logic       lock_en[N];
  int         mode, ack_at, busy_extra, eng_cnt;   // mode 0 ack, 1 timeout, 2 both
  bit         busy_fell;
  logic       gv_at_fall;
  int         last_fall, we_cyc, we_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = (issued[k] != accepted[k]);
      req_data[8*k +: 8] = base[k] + 8'(accepted[k]);
      req_lock[k]        = lock_en[k] & req_valid[k];
    end
  endtask

  task automatic post(input int k, input int n, input logic [7:0] b, input logic lk);
    issued[k]   = n;
    accepted[k] = 0;
    base[k]     = b;
    lock_en[k]  = lk;
    drive_reqs();
  endtask

  task automatic exp_w(input int k, input logic [7:0] d, input logic r);
    wexp_t e;
    e.id = 2'(k); e.data = d; e.rdy = r;
    wq.push_back(e);
  endtask

  task automatic exp_c(input int k, input logic err);
    cexp_t e;
    e.id = 2'(k); e.err = err;
    cq.push_back(e);
  endtask

  // One clock: sample DUT at negedge, score it, then update requesters and engine model.
  task automatic tick();
    wexp_t    we_e;
    cexp_t    c_e;
    logic [N-1:0] oh;
    @(negedge clk);
    cyc++;
    if (write_enable === 1'b1) begin
      we_cyc = cyc;
      we_count++;
      chk("we_while_busy", 32'(write_busy), 32'd0);
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'(write_enable), 32'd0);
      end else begin
        we_e = wq.pop_front();
        oh   = N'(1) << we_e.id;
        $display("write id=%0d data=%02h ready=%b", grant_id, write_data, req_ready);
        chk("write_id", 32'(grant_id), 32'(we_e.id));
        chk("write_data", 32'(write_data), 32'(we_e.data));
        chk("write_ready", 32'(req_ready), we_e.rdy ? 32'(oh) : 32'd0);
        chk("write_grant_valid", 32'(grant_valid), 32'd1);
      end
    end else begin
      chk("ready_without_write", 32'(req_ready), 32'd0);
    end
    if (req_done !== '0 || req_err !== '0) begin
      if (cq.size() == 0) begin
        chk("unexpected_completion", 32'({req_done, req_err}), 32'd0);
      end else begin
        c_e = cq.pop_front();
        oh  = N'(1) << c_e.id;
        $display("complete done=%b err=%b", req_done, req_err);
        chk("req_done", 32'(req_done), c_e.err ? 32'd0 : 32'(oh));
        chk("req_err", 32'(req_err), c_e.err ? 32'(oh) : 32'd0);
      end
    end
    for (int k = 0; k < N; k++)
      if (req_ready[k] === 1'b1 && accepted[k] != issued[k]) accepted[k]++;
    drive_reqs();
    if (write_enable === 1'b1) begin
      write_busy = 1'b1;
      eng_cnt    = 1;
    end else if (eng_cnt != 0) begin
      eng_cnt++;
      if (eng_cnt == ack_at) begin
        write_ack         = (mode == 0 || mode == 2);
        write_ack_timeout = (mode != 0);
      end
      if (eng_cnt == ack_at + 1) begin
        write_ack         = 1'b0;
        write_ack_timeout = 1'b0;
      end
      if (eng_cnt == ack_at + 1 + busy_extra) begin
        gv_at_fall = grant_valid;
        busy_fell  = 1'b1;
        last_fall  = cyc;
        write_busy = 1'b0;
        eng_cnt    = 0;
      end
    end
  endtask

  task automatic wait_quiet(input int max);
    int n = 0;
    while ((wq.size() != 0 || cq.size() != 0 || req_valid != '0 || eng_cnt != 0 ||
            grant_valid !== 1'b0) && n < max) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(wq.size() + cq.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, fall_c, n0;
    total = 0; bad = 0; cyc = 0;
    mode = 0; ack_at = 3; busy_extra = 0; eng_cnt = 0;
    busy_fell = 1'b0; gv_at_fall = 1'b0; last_fall = 0; we_cyc = 0; we_count = 0;
    write_busy = 1'b0; write_ack = 1'b0; write_ack_timeout = 1'b0;
    for (int k = 0; k < N; k++) begin
      issued[k] = 0; accepted[k] = 0; base[k] = 8'h00; lock_en[k] = 1'b0;
    end
    req_valid = '0; req_data = '0; req_lock = '0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", 32'({req_ready, req_done, req_err, grant_valid, grant_id,
                              write_enable, write_data}), 32'd0);

    // Single requester: 2-cycle latency, done, grant drops after busy.
    post(0, 1, 8'hA5, 1'b0);
    exp_w(0, 8'hA5, 1'b1);
    exp_c(0, 1'b0);
    busy_fell = 1'b0;
    tick();
    chk("latency_cycle1_we", 32'(write_enable), 32'd0);
    tick();
    chk("latency_cycle2_we", 32'(write_enable), 32'd1);
    chk("latency_cycle2_data", 32'(write_data), 32'hA5);
    chk("latency_cycle2_ready", 32'(req_ready), 32'b0001);
    n = 0;
    while (!busy_fell && n < 50) begin tick(); n++; end
    tick();
    chk("grant_before_busy_fall", 32'(gv_at_fall), 32'd1);
    chk("grant_after_busy_fall", 32'(grant_valid), 32'd0);
    wait_quiet(50);

    // Round-robin over all four, two bytes each.
    do_reset();
    for (int k = 0; k < N; k++) post(k, 2, 8'(8'h40 + 16 * k), 1'b0);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) begin
        exp_w(k, 8'(8'h40 + 16 * k + r), 1'b1);
        exp_c(k, 1'b0);
      end
    wait_quiet(300);

    // Move the pointer to 1, then a locked 3-byte frame from 2 against 0, 1 and 3.
    post(1, 1, 8'h77, 1'b0);
    exp_w(1, 8'h77, 1'b1); exp_c(1, 1'b0);
    wait_quiet(50);
    post(0, 1, 8'h80, 1'b0);
    post(1, 1, 8'h90, 1'b0);
    post(2, 3, 8'hC0, 1'b1);
    post(3, 1, 8'hE0, 1'b0);
    exp_w(2, 8'hC0, 1'b1); exp_c(2, 1'b0);
    exp_w(2, 8'hC1, 1'b1); exp_c(2, 1'b0);
    exp_w(2, 8'hC2, 1'b1); exp_c(2, 1'b0);
    exp_w(3, 8'hE0, 1'b1); exp_c(3, 1'b0);
    exp_w(0, 8'h80, 1'b1); exp_c(0, 1'b0);
    exp_w(1, 8'h90, 1'b1); exp_c(1, 1'b0);
    wait_quiet(300);

    // Back-pressure: busy held 10 cycles after ack.
    busy_extra = 10;
    busy_fell  = 1'b0;
    post(1, 2, 8'h33, 1'b0);
    exp_w(1, 8'h33, 1'b1); exp_c(1, 1'b0);
    exp_w(1, 8'h34, 1'b1); exp_c(1, 1'b0);
    n = 0;
    while (!busy_fell && n < 60) begin tick(); n++; end
    fall_c = last_fall;
    n0     = we_count;
    n = 0;
    while (we_count == n0 && n < 60) begin tick(); n++; end
    chk("backpressure_gap", 32'(we_cyc - fall_c), 32'd3);
    wait_quiet(100);
    busy_extra = 0;

    // Timeout without ack.
    mode = 1;
    post(3, 1, 8'h5A, 1'b0);
`ifdef UART_TX_ARB_RETRY_EN
    exp_w(3, 8'h5A, 1'b1);
    exp_w(3, 8'h5A, 1'b0);
    exp_w(3, 8'h5A, 1'b0);
`else
    exp_w(3, 8'h5A, 1'b1);
`endif
    exp_c(3, 1'b1);
    wait_quiet(100);

    // Ack and timeout together: ack wins.
    mode = 2;
    post(0, 1, 8'h3C, 1'b0);
    exp_w(0, 8'h3C, 1'b1); exp_c(0, 1'b0);
    wait_quiet(50);
    mode = 0;

    // Reset while waiting for ack; the late ack is ignored and 0 wins next.
    ack_at = 10;
    post(1, 1, 8'h66, 1'b0);
    exp_w(1, 8'h66, 1'b1);
    n = 0;
    while (wq.size() != 0 && n < 20) begin tick(); n++; end
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("reset_mid_outputs", 32'({req_ready, req_done, req_err, grant_valid, grant_id,
                                  write_enable, write_data}), 32'd0);
    rst = 1'b0;
    post(0, 1, 8'h11, 1'b0);
    post(2, 1, 8'h22, 1'b0);
    exp_w(0, 8'h11, 1'b1); exp_c(0, 1'b0);
    exp_w(2, 8'h22, 1'b1); exp_c(2, 1'b0);
    wait_quiet(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
